closest_hit_reduce: RTL and testbench
=====================================

# closest_hit_reduce

Reduces the stream of per-box intersection results for one ray into a single nearest-hit record. Sits directly downstream of the AABB slab-test stage: the ray dispatcher announces a ray and its box count, the AABB stage emits one `AABB_result_t` per box (no backpressure), and this block keeps the smallest positive `tmin` among hits. It then presents the winning box, `tmin`, normal and index to the shading stage over a valid/ready handshake.

## Interface
- `WIDTH`, 20: fixed-point word width (Q format shared with the AABB stage).
- `Q_BITS`, 12: fractional bits.
- `MAX_BOXES`, 16: maximum boxes per ray. `CNT_W = $clog2(MAX_BOXES+1)`, `IDX_W = $clog2(MAX_BOXES)`.
- `MAX`, 20'h7FFFF: "no hit" distance sentinel.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ray_start`  in  1  begin a new ray; accepted only when `start_ready`.
- `box_count`  in  CNT_W  number of results to expect; sampled with accepted `ray_start`.
- `start_ready`  out  1  high in IDLE only.
- `in_valid`  in  1  AABB result valid (AABB `valid_out`).
- `in_result`  in  AABB_result_t  box, ray_hit, tmin, normal.
- `out_valid`  out  1  final record valid.
- `out_ready`  in  1  consumer accepts record.
- `out_hit`  out  closest_hit_t  {hit, tmin, normal, box, box_idx}.
- `protocol_err`  out  1  sticky: result arrived outside ACCUM.

## Operation
- FSM states IDLE, ACCUM, DONE.
- IDLE: `start_ready`=1. On `ray_start`: `remaining` <= `box_count`, `idx` <= 0, best <= {hit 0, tmin MAX, normal 0, box 0, box_idx 0}. Go ACCUM if `box_count`≠0, else DONE (miss record).
- ACCUM: each `in_valid` cycle: if `in_result.ray_hit` and `in_result.tmin` < best.tmin (signed, strict), best <= {1, tmin, normal, box, idx}. `idx`++, `remaining`--. When `remaining`==1 and `in_valid`, update best with that result and go DONE.
- Ties: strict compare keeps the earlier box. Non-hit results never replace best, whatever their `tmin`.
- DONE: `out_valid`=1, `out_hit`=best held stable until `out_ready`. On `out_valid && out_ready` go IDLE.
- `in_valid` in IDLE or DONE: result dropped, `protocol_err` <= 1 (cleared only by reset).
- `box_count` > `MAX_BOXES`: saturate to `MAX_BOXES`.

## Timing
- Reset values: state IDLE, `start_ready` 1 (the combinational decode of IDLE), `out_valid` 0, `out_hit` = {0, MAX, 0, 0, 0}, `protocol_err` 0.
- Reset mid-ACCUM or mid-DONE: abandon the ray, no output, back to IDLE next cycle.
- One result is accepted per cycle at full rate. Gaps in `in_valid` are allowed.
- Latency: last result at cycle N -> `out_valid` high at N+1.
- Zero-box ray: `ray_start` at N -> `out_valid` at N+1.
- Earliest next `ray_start` is the cycle after the handshake.
- `ray_start` and `in_valid` in the same IDLE cycle: the start is taken, the result is dropped, and `protocol_err` is set.
- `out_hit` is registered. No combinational path from `in_*` to `out_*`.

## Structure
- Shared package (Types.sv): `closest_hit_t` typedef {logic hit; logic signed [WIDTH-1:0] tmin; Vec3_t normal; AABB box; logic [IDX_W-1:0] box_idx}.
- Parameters.sv: the `MAX` sentinel, kept shared with the AABB stage.
- No sub-module: the comparator and FSM fit in one module.

## Test plan
- Start `box_count`=3. Results: {hit 1, tmin 0x02000}, {hit 1, tmin 0x01000}, {hit 1, tmin 0x03000} -> `out_hit` {hit 1, tmin 0x01000, box_idx 1}, one cycle after the third result.
- Start `box_count`=2. Both results have `ray_hit`=0, `tmin`=0 -> {hit 0, tmin 0x7FFFF}.
- Start `box_count`=0 -> `out_valid` next cycle, miss record.
- Tie: `box_count`=2, both hit with `tmin` 0x00800 -> `box_idx` 0.
- Hold `out_ready`=0 for 5 cycles. Drive `ray_start` and a stray `in_valid` meanwhile -> `out_hit` stable, `start_ready` 0, start ignored, `protocol_err`=1.
- Assert `reset` after 2 of 4 results -> IDLE and `out_valid`=0. A new 1-box ray then completes normally.

Source files
------------

// File: rtl/closest_hit_reduce_pkg.sv
// Shared types and constants for the closest-hit reduction stage and its AABB producer.
package closest_hit_reduce_pkg;

  localparam int unsigned WIDTH     = 20;
  localparam int unsigned Q_BITS    = 12;
  localparam int unsigned MAX_BOXES = 16;
  localparam int unsigned CNT_W     = $clog2(MAX_BOXES + 1);
  localparam int unsigned IDX_W     = $clog2(MAX_BOXES);

  // "No hit" distance sentinel, shared with the AABB stage.
  localparam logic signed [WIDTH-1:0] MAX = WIDTH'(20'h7FFFF);

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
  } Vec3_t;

  typedef struct packed {
    Vec3_t lo;
    Vec3_t hi;
  } AABB;

  typedef struct packed {
    AABB                     box;
    logic                    ray_hit;
    logic signed [WIDTH-1:0] tmin;
    Vec3_t                   normal;
  } AABB_result_t;

  typedef struct packed {
    logic                    hit;
    logic signed [WIDTH-1:0] tmin;
    Vec3_t                   normal;
    AABB                     box;
    logic [IDX_W-1:0]        box_idx;
  } closest_hit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam closest_hit_t MISS_HIT = '{
    hit:     1'b0,
    tmin:    MAX,
    normal:  '0,
    box:     '0,
    box_idx: '0
  };

endpackage

// File: rtl/closest_hit_reduce.sv
// Reduces one ray's stream of AABB results to the nearest hit and hands it to shading.
module closest_hit_reduce
  import closest_hit_reduce_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ray_start,
  input  logic [CNT_W-1:0]   box_count,
  output logic               start_ready,
  input  logic               in_valid,
  input  AABB_result_t       in_result,
  output logic               out_valid,
  input  logic               out_ready,
  output closest_hit_t       out_hit,
  output logic               protocol_err
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count_sat;
  logic             take;

  assign start_ready = (state == IDLE);

  assign count_sat = (box_count > CNT_W'(MAX_BOXES)) ? CNT_W'(MAX_BOXES) : box_count;

  // Strict compare so ties keep the earlier box; misses never win.
  assign take = in_result.ray_hit &&
                ($signed(in_result.tmin) < $signed(out_hit.tmin));

  // out_hit doubles as the running-best register so it is stable through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      idx          <= '0;
      out_valid    <= 1'b0;
      out_hit      <= MISS_HIT;
      protocol_err <= 1'b0;
    end else begin
      if (in_valid && (state != ACCUM)) begin
        protocol_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ray_start) begin
            remaining <= count_sat;
            idx       <= '0;
            out_hit   <= MISS_HIT;
            if (count_sat == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (in_valid) begin
            if (take) begin
              out_hit <= '{
                hit:     1'b1,
                tmin:    in_result.tmin,
                normal:  in_result.normal,
                box:     in_result.box,
                box_idx: idx
              };
            end
            idx       <= IDX_W'(idx + 1'b1);
            remaining <= CNT_W'(remaining - 1'b1);
            if (remaining == CNT_W'(1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_closest_hit_reduce.sv
// Directed self-checking bench for closest_hit_reduce.
module tb_closest_hit_reduce;
  import closest_hit_reduce_pkg::*;

  logic         clk;
  logic         reset;
  logic         ray_start;
  logic [CNT_W-1:0] box_count;
  logic         start_ready;
  logic         in_valid;
  AABB_result_t in_result;
  logic         out_valid;
  logic         out_ready;
  closest_hit_t out_hit;
  logic         protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  closest_hit_reduce dut (
    .clk          (clk),
    .reset        (reset),
    .ray_start    (ray_start),
    .box_count    (box_count),
    .start_ready  (start_ready),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hit      (out_hit),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic Vec3_t mk_norm(input int i);
    return '{x: WIDTH'(i + 1), y: WIDTH'(2 * i), z: WIDTH'(3 * i + 7)};
  endfunction

  function automatic AABB mk_box(input int i);
    return '{lo: '{x: WIDTH'(i), y: WIDTH'(i + 3), z: WIDTH'(i + 5)},
             hi: '{x: WIDTH'(i + 100), y: WIDTH'(i + 200), z: WIDTH'(i + 300)}};
  endfunction

  function automatic closest_hit_t mk_hit(input logic [WIDTH-1:0] t, input int id,
                                          input int pos);
    return '{hit: 1'b1, tmin: t, normal: mk_norm(id), box: mk_box(id),
             box_idx: IDX_W'(pos)};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ray(input int cnt);
    ray_start = 1'b1;
    box_count = CNT_W'(cnt);
    tick();
    ray_start = 1'b0;
  endtask

  task automatic send(input logic hit, input logic [WIDTH-1:0] t, input int id);
    in_result = '{box: mk_box(id), ray_hit: hit, tmin: t, normal: mk_norm(id)};
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_hit !== MISS_HIT) begin n_err++; $display("FAIL reset_out_hit: got %h want %h", out_hit, MISS_HIT); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_protocol_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_nearest();
    closest_hit_t exp;
    exp = mk_hit(20'h01000, 11, 1);
    start_ray(3);
    n_cmp++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL nearest_busy: got %b want 0", start_ready); end
    send(1'b1, 20'h02000, 10);
    tick();
    send(1'b1, 20'h01000, 11);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nearest_early_valid: got %b want 0", out_valid); end
    send(1'b1, 20'h03000, 12);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nearest_latency: got %b want 1", out_valid); end
    n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL nearest_record: got %h want %h", out_hit, exp); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin n_err++; $display("FAIL nearest_release: got valid %b ready %b want 0 1", out_valid, start_ready); end
  endtask

  task automatic test_all_miss();
    start_ray(2);
    send(1'b0, 20'h00000, 20);
    send(1'b0, 20'h00000, 21);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL miss_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_hit.hit !== 1'b0 || out_hit.tmin !== 20'h7FFFF) begin n_err++; $display("FAIL miss_record: got hit %b tmin %h want 0 7ffff", out_hit.hit, out_hit.tmin); end
    handshake();
  endtask

  task automatic test_zero_box();
    start_ray(0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_hit !== MISS_HIT) begin n_err++; $display("FAIL zero_record: got %h want %h", out_hit, MISS_HIT); end
    handshake();
  endtask

  task automatic test_tie();
    closest_hit_t exp;
    exp = mk_hit(20'h00800, 30, 0);
    start_ray(2);
    send(1'b1, 20'h00800, 30);
    send(1'b1, 20'h00800, 31);
    n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL tie_record: got %h want %h", out_hit, exp); end
    handshake();
  endtask

  task automatic test_saturate();
    closest_hit_t exp;
    exp = mk_hit(20'h00100, 79, 9);
    start_ray(20);
    for (int i = 0; i < 15; i++) begin
      send(1'b1, (i == 9) ? 20'h00100 : WIDTH'(20'h04000 + i), 70 + i);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_early_valid: got %b want 0", out_valid); end
    send(1'b0, 20'h00001, 85);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL sat_record: got %h want %h", out_hit, exp); end
    handshake();
  endtask

  task automatic test_stall();
    closest_hit_t exp;
    exp = mk_hit(20'h00400, 40, 0);
    start_ray(1);
    send(1'b1, 20'h00400, 40);
    ray_start = 1'b1;
    box_count = CNT_W'(3);
    in_result = '{box: mk_box(41), ray_hit: 1'b1, tmin: 20'h00001, normal: mk_norm(41)};
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || start_ready !== 1'b0) begin n_err++; $display("FAIL stall_flags[%0d]: got valid %b ready %b want 1 0", c, out_valid, start_ready); end
      n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", c, out_hit, exp); end
    end
    ray_start = 1'b0;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL stall_protocol_err: got %b want 1", protocol_err); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got valid %b ready %b want 0 1", out_valid, start_ready); end
  endtask

  task automatic test_reset_mid();
    closest_hit_t exp;
    exp = mk_hit(20'h00300, 50, 0);
    start_ray(4);
    send(1'b1, 20'h00500, 45);
    send(1'b1, 20'h00200, 46);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got valid %b ready %b want 0 1", out_valid, start_ready); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rmid_err_cleared: got %b want 0", protocol_err); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_output: got %b want 0", out_valid); end
    start_ray(1);
    send(1'b1, 20'h00300, 50);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_new_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL rmid_new_record: got %h want %h", out_hit, exp); end
    handshake();
  endtask

  task automatic test_back_to_back();
    closest_hit_t exp;
    exp = mk_hit(20'h00900, 62, 0);
    start_ray(1);
    send(1'b1, 20'h00200, 60);
    handshake();
    // New ray on the very next cycle, with a stray result in the same cycle.
    ray_start = 1'b1;
    box_count = CNT_W'(1);
    in_result = '{box: mk_box(61), ray_hit: 1'b1, tmin: 20'h00100, normal: mk_norm(61)};
    in_valid  = 1'b1;
    tick();
    ray_start = 1'b0;
    in_valid  = 1'b0;
    n_cmp++; if (start_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_accepted: got ready %b valid %b want 0 0", start_ready, out_valid); end
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL b2b_protocol_err: got %b want 1", protocol_err); end
    send(1'b1, 20'h00900, 62);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_hit !== exp) begin n_err++; $display("FAIL b2b_record: got %h want %h", out_hit, exp); end
    handshake();
  endtask

  initial begin
    reset     = 1'b1;
    ray_start = 1'b0;
    box_count = '0;
    in_valid  = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    test_reset();
    test_nearest();
    test_all_miss();
    test_zero_box();
    test_tie();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
